adc_channel_guard: RTL and testbench

//  Per-channel sample qualifier between the ADC FIFO read side and pid_pipeline.

---
 rtl/adc_channel_guard.sv | 132 +++++++++++++
 tb/tb_adc_channel_guard.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adc_channel_guard.sv
// Per-channel ADC sample qualifier: debounced kill, zero-run faults,
// sticky host-cleared faults and a bypass mask, one-cycle registered output.
module adc_channel_guard #(
  parameter int N_CHAN     = 8,
  parameter int W_CHAN     = 3,
  parameter int W_DATA     = 16,
  parameter int DEB_CYC    = 8,
  parameter int ZERO_LIMIT = 4,
  parameter int W_WR_ADDR  = 16,
  parameter int W_WR_DATA  = 16,
  parameter int MASK_ADDR  = 'h40,
  parameter int CLR_ADDR   = 'h41,
  parameter int MODE_ADDR  = 'h42
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N_CHAN-1:0]    shutdown_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_DATA-1:0] wr_data,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out,
  output logic [N_CHAN-1:0]    fault_out,
  output logic                 fault_evt_out
);

  localparam int W_DC = $clog2(DEB_CYC + 1);
  localparam int W_ZC = $clog2(ZERO_LIMIT + 1);
  localparam logic [W_DC-1:0] DL = W_DC'(DEB_CYC - 1);
  localparam logic [W_ZC-1:0] ZL = W_ZC'(ZERO_LIMIT);

  logic [N_CHAN-1:0] sh1, sh2, kill_db;
  logic [W_DC-1:0]   dcnt [N_CHAN];
  logic [W_ZC-1:0]   zc [N_CHAN];
  logic [W_ZC-1:0]   zc_nxt [N_CHAN];
  logic [N_CHAN-1:0] mask, hit, fault_nxt;
  logic [1:0]        mode;
  logic              pass, trip, is_zero;
  logic              mask_wr, clr_wr, mode_wr;
  logic              unused_wr;

  assign unused_wr = ^wr_data;
  assign mask_wr = wr_en && wr_addr == W_WR_ADDR'(MASK_ADDR);
  assign clr_wr  = wr_en && wr_addr == W_WR_ADDR'(CLR_ADDR);
  assign mode_wr = wr_en && wr_addr == W_WR_ADDR'(MODE_ADDR);
  assign is_zero = data_in == '0;

  // One-hot channel decode; out-of-range channels never hit.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CHAN; c++)
      hit[c] = dv_in && chan_in == W_CHAN'(c);
  end

  always_comb begin
    fault_nxt = fault_out;
    pass = 1'b0;
    trip = 1'b0;
    for (int c = 0; c < N_CHAN; c++) begin
      zc_nxt[c] = zc[c];
      if (clr_wr && wr_data[c]) begin
        fault_nxt[c] = 1'b0;
        zc_nxt[c] = '0;
      end
      if (hit[c]) begin
        if (mask[c]) begin
          pass = 1'b1;
        end else begin
          if (is_zero) begin
            zc_nxt[c] = (zc[c] == ZL) ? ZL : zc[c] + W_ZC'(1);
            trip = zc_nxt[c] == ZL;
          end else begin
            zc_nxt[c] = '0;
          end
          pass = !(fault_out[c] || kill_db[c] || trip ||
                   (is_zero && mode[0]));
          if (trip) fault_nxt[c] = 1'b1;
        end
      end
      if (!mask[c] && kill_db[c] && mode[1]) fault_nxt[c] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sh1 <= '0;
      sh2 <= '0;
      kill_db <= '0;
      for (int c = 0; c < N_CHAN; c++) begin
        dcnt[c] <= '0;
        zc[c] <= '0;
      end
      mask <= '0;
      mode <= 2'b11;
      fault_out <= '0;
      fault_evt_out <= 1'b0;
      dv_out <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
    end else begin
      sh1 <= shutdown_in;
      sh2 <= sh1;
      for (int c = 0; c < N_CHAN; c++) begin
        if (sh2[c] != kill_db[c]) begin
          if (dcnt[c] == DL) begin
            kill_db[c] <= ~kill_db[c];
            dcnt[c] <= '0;
          end else begin
            dcnt[c] <= dcnt[c] + W_DC'(1);
          end
        end else begin
          dcnt[c] <= '0;
        end
        zc[c] <= zc_nxt[c];
      end
      if (mask_wr) mask <= wr_data[N_CHAN-1:0];
      if (mode_wr) mode <= wr_data[1:0];
      fault_out <= fault_nxt;
      fault_evt_out <= |(fault_nxt & ~fault_out);
      dv_out <= pass;
      if (pass) begin
        chan_out <= chan_in;
        data_out <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_adc_channel_guard.sv
// Directed bench for adc_channel_guard; 4-bit channel index so that
// out-of-range channels can be exercised.
module tb_adc_channel_guard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  shutdown = '0;
  logic        dv = 1'b0;
  logic [3:0]  chan = '0;
  logic [15:0] data = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        dv_out;
  logic [3:0]  chan_out;
  logic [15:0] data_out;
  logic [7:0]  fault_out;
  logic        fault_evt_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_channel_guard #(.W_CHAN(4)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .shutdown_in(shutdown),
    .dv_in(dv),
    .chan_in(chan),
    .data_in(data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .dv_out(dv_out),
    .chan_out(chan_out),
    .data_out(data_out),
    .fault_out(fault_out),
    .fault_evt_out(fault_evt_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [3:0] c, input logic [15:0] d);
    dv = 1'b1;
    chan = c;
    data = d;
    tick();
    dv = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_dv", dv_out, 0);
    chk("rst_fault", fault_out, 0);
    chk("rst_data", data_out, 0);
    rst = 1'b0;
    tick();

    // 1: plain pass
    sample(4'd2, 16'h1234);
    chk("t1_dv", dv_out, 1);
    chk("t1_chan", chan_out, 2);
    chk("t1_data", data_out, 16'h1234);
    chk("t1_fault", fault_out, 0);

    // 2: zero run on ch3
    for (int i = 0; i < 4; i++) begin
      sample(4'd3, 16'h0000);
      chk("t2_dv", dv_out, 0);
      chk("t2_f3", fault_out[3], i == 3);
      chk("t2_evt", fault_evt_out, i == 3);
    end
    tick();
    chk("t2_evt_once", fault_evt_out, 0);
    sample(4'd3, 16'h0005);
    chk("t2_drop", dv_out, 0);
    chk("t2_hold", data_out, 16'h1234);

    // 3: host clear
    host_wr(16'h41, 16'h0008);
    chk("t3_clr", fault_out, 0);
    sample(4'd3, 16'h0005);
    chk("t3_dv", dv_out, 1);
    chk("t3_data", data_out, 16'h0005);

    // 4: debounced kill on ch1
    shutdown[1] = 1'b1;
    dv = 1'b1;
    chan = 4'd1;
    data = 16'h0011;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t4_dv", dv_out, k <= 9);
      chk("t4_f1", fault_out[1], k >= 10);
      chk("t4_evt", fault_evt_out, k == 10);
    end
    dv = 1'b0;
    host_wr(16'h41, 16'h0002);
    chk("t4_clr_kill", fault_out[1], 1);

    // 5: mask bypass on ch0
    host_wr(16'h40, 16'h0001);
    shutdown[0] = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 5; i++) begin
      sample(4'd0, 16'h0000);
      chk("t5_dv", dv_out, 1);
    end
    chk("t5_fault", fault_out, 8'h02);
    sample(4'd9, 16'h0077);
    chk("t5_oor_dv", dv_out, 0);
    chk("t5_oor_chan", chan_out, 0);
    chk("t5_fault2", fault_out, 8'h02);

    // 6: async reset mid-stream
    sample(4'd0, 16'hABCD);
    chk("t6_pre", dv_out, 1);
    dv = 1'b1;
    rst = 1'b1;
    #2;
    chk("t6_dv", dv_out, 0);
    chk("t6_data", data_out, 0);
    chk("t6_fault", fault_out, 0);
    dv = 1'b0;
    shutdown = '0;
    tick();
    rst = 1'b0;
    tick();
    sample(4'd0, 16'h0000);
    chk("t6_mask0", dv_out, 0);
    sample(4'd0, 16'h0009);
    chk("t6_pass", dv_out, 1);

    // zero_drop off: trip sample still dropped
    host_wr(16'h42, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      sample(4'd4, 16'h0000);
      chk("m0_dv", dv_out, i < 3);
      chk("m0_f4", fault_out[4], i == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
